// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the multi-port register file.
package regfile_pkg;

  localparam int          DW_DEF      = 32;
  localparam int          AW_DEF      = 5;
  localparam int          SP_IDX_DEF  = 20;
  localparam logic [31:0] SP_INIT_DEF = 32'h7FFF_FFF0;

  // CLEAR walks the array writing reset values; RUN is normal operation.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: a write retires the producer, a reserve marks a
// new one. Register 0 never reads busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          we0,
  input  logic [AW-1:0] wreg0,
  input  logic          we1,
  input  logic [AW-1:0] wreg1,
  input  logic          rsv,
  input  logic [AW-1:0] rsv_reg,
  input  logic [AW-1:0] rreg1,
  input  logic [AW-1:0] rreg2,
  output logic          busy1,
  output logic          busy2
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] busy_q, busy_d;

  // Next busy vector: clears from writes first, then the reserve set on top.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    busy_d = busy_q;
    if (run) begin
      if (we0 && (wreg0 != '0)) busy_d[wreg0] = 1'b0;
      if (we1 && (wreg1 != '0)) busy_d[wreg1] = 1'b0;
      // Applied after the clears so a same-cycle reserve marks the new producer.
      if (rsv && (rsv_reg != '0)) busy_d[rsv_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy register with synchronous clear on reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Read taps see registered state only; same-cycle set/clear is not forwarded.
  assign busy1 = run & busy_q[rreg1];
  assign busy2 = run & busy_q[rreg2];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritized write ports, two combinational
// read ports with optional forwarding, a busy scoreboard and a sequential
// clear engine that rebuilds reset contents after every reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int            DW      = DW_DEF,
  parameter int            AW      = AW_DEF,
  parameter int            SP_IDX  = SP_IDX_DEF,
  parameter logic [DW-1:0] SP_INIT = DW'(SP_INIT_DEF),
  parameter bit            BYPASS  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  input  logic          we0,
  input  logic [AW-1:0] wreg0,
  input  logic [DW-1:0] wdata0,
  input  logic          we1,
  input  logic [AW-1:0] wreg1,
  input  logic [DW-1:0] wdata1,
  input  logic          rsv,
  input  logic [AW-1:0] rsv_reg,
  input  logic [AW-1:0] rreg1,
  input  logic [AW-1:0] rreg2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic          busy1,
  output logic          busy2
);

  localparam int            NREG     = 1 << AW;
  localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] SP_ADDR  = AW'(SP_IDX);

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            ready_q, ready_d;
  logic [DW-1:0]   rh_q [NREG];
  logic [DW-1:0]   rh_d [NREG];
  logic            run;

  assign run   = (state_q == ST_RUN);
  assign ready = ready_q;

  // Clear FSM: step idx through every register, then enter RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    if (state_q == ST_CLEAR) begin
      if (idx_q == IDX_LAST) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end else begin
        idx_d = idx_q + AW'(1);
      end
    end
  end

  // Control registers; reset restarts the clear sequence from either state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Array next state: one clear write per cycle in CLEAR, port writes in RUN.
  always_comb begin
    rh_d = rh_q;
    if (state_q == ST_CLEAR) begin
      rh_d[idx_q] = (idx_q == SP_ADDR) ? SP_INIT : '0;
    end else begin
      if (we1 && (wreg1 != '0)) rh_d[wreg1] = wdata1;
      // Port 0 is applied last so it wins a same-register collision.
      if (we0 && (wreg0 != '0)) rh_d[wreg0] = wdata0;
    end
  end

  // Storage array; held during reset, rebuilt afterwards by the clear engine.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term; the clear engine restores contents, keeping the storage plain flops/RAM.
    if (!rst) rh_q <= rh_d;
  end

  logic [AW-1:0] rreg_a  [2];
  logic [DW-1:0] rdata_a [2];

  assign rreg_a[0] = rreg1;
  assign rreg_a[1] = rreg2;
  assign rdata1    = rdata_a[0];
  assign rdata2    = rdata_a[1];

  // Read muxes: zero in CLEAR or for register 0, optional forwarding of writes.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rdata_a[k] = '0;
      if (run && (rreg_a[k] != '0)) begin
        rdata_a[k] = rh_q[rreg_a[k]];
        if (BYPASS) begin
          if (we0 && (wreg0 == rreg_a[k]))      rdata_a[k] = wdata0;
          else if (we1 && (wreg1 == rreg_a[k])) rdata_a[k] = wdata1;
        end
      end
    end
  end

  regfile_scoreboard #(.AW(AW)) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .we0     (we0),
    .wreg0   (wreg0),
    .we1     (we1),
    .wreg1   (wreg1),
    .rsv     (rsv),
    .rsv_reg (rsv_reg),
    .rreg1   (rreg1),
    .rreg2   (rreg2),
    .busy1   (busy1),
    .busy2   (busy2)
  );

endmodule
